// File: rtl/shift_pkg.sv
// Shared command codes and state encoding for the 74HC595-chain frame sequencer
// and the shift driver it controls.
package shift_pkg;

    localparam logic [1:0] CMD_CLR = 2'b00;
    localparam logic [1:0] CMD_SFT = 2'b01;
    localparam logic [1:0] CMD_LAT = 2'b10;
    localparam logic [1:0] CMD_OE  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OE    = 3'd1,
        ST_CLR   = 3'd2,
        ST_CWAIT = 3'd3,
        ST_SHIFT = 3'd4,
        ST_SWAIT = 3'd5,
        ST_LATCH = 3'd6,
        ST_LWAIT = 3'd7
    } state_e;

endpackage

// File: rtl/shift_ctrl.sv
// Frame sequencer for the 595-chain driver: optional clear, NBYTE shifts, latch,
// and output-enable updates. Optional pre-frame clear enabled by SFT_PRECLR_EN.
module shift_ctrl
    import shift_pkg::*;
#(
    parameter int NBYTE  = 4,
    parameter int TO_CYC = 127
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frm_vld,
    input  logic [8*NBYTE-1:0] frm_data,
    output logic               frm_rdy,
    output logic               frm_done,
    input  logic               oe_req,
    input  logic               oe_val,
    output logic               busy,
    output logic               err,
    input  logic               err_clr,
    output logic               sft_vld,
    output logic [1:0]         sft_cmd,
    output logic               sft_cmd_oen,
    output logic [7:0]         sft_din,
    input  logic               sft_done
);

    localparam logic [3:0] IDX_LAST = 4'(NBYTE - 1);
    localparam logic [6:0] TO_LIM   = 7'(TO_CYC);

    state_e             state_r, state_s;
    logic [3:0]         idx_r, idx_s;
    logic [8*NBYTE-1:0] frame_r;
    logic [8*NBYTE-1:0] img_s;
    logic [6:0]         cnt_r;
    logic               oe_pend_r, oe_pend_s;
    logic               oe_lvl_r, oe_lvl_s;
    logic               err_r;
    logic               accept_s, timeout_s, done_s;

    logic               vld_s, oen_s, rdy_s, busy_s;
    logic [1:0]         cmd_s;
    logic [7:0]         din_s;

    logic               sft_vld_r, sft_oen_r, frm_rdy_r, frm_done_r, busy_r;
    logic [1:0]         sft_cmd_r;
    logic [7:0]         sft_din_r;

    // The first shift of a no-clear frame is issued on the accept edge, before frame_r holds the image
    assign img_s = (state_r == ST_IDLE) ? frm_data : frame_r;

    // Next-state, byte index, pending OE and event decode
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        accept_s  = 1'b0;
        timeout_s = 1'b0;
        done_s    = 1'b0;
        if (oe_req) begin
            oe_pend_s = 1'b1;
            oe_lvl_s  = oe_val;
        end else begin
            oe_pend_s = oe_pend_r;
            oe_lvl_s  = oe_lvl_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (oe_req || oe_pend_r) begin
                    state_s   = ST_OE;
                    oe_pend_s = 1'b0;
                end else if (frm_vld && frm_rdy_r) begin
                    accept_s = 1'b1;
                    idx_s    = IDX_LAST;
`ifdef SFT_PRECLR_EN
                    state_s  = ST_CLR;
`else
                    state_s  = ST_SHIFT;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OE: state_s = ST_IDLE;
`ifdef SFT_PRECLR_EN
            ST_CLR: state_s = ST_CWAIT;
            ST_CWAIT: begin
                if (cnt_r == 7'd1) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_CWAIT;
                end
            end
`endif
            ST_SHIFT: state_s = ST_SWAIT;
            ST_SWAIT: begin
                if (sft_done) begin
                    if (idx_r == 4'd0) begin
                        state_s = ST_LATCH;
                    end else begin
                        idx_s   = idx_r - 4'd1;
                        state_s = ST_SHIFT;
                    end
                end else if (cnt_r == TO_LIM) begin
                    timeout_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_SWAIT;
                end
            end
            ST_LATCH: state_s = ST_LWAIT;
            ST_LWAIT: begin
                if (sft_done) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else if (cnt_r == TO_LIM) begin
                    timeout_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_LWAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Command strobe and handshake outputs derived from the state being entered
    always_comb begin
        vld_s = 1'b0;
        cmd_s = sft_cmd_r;
        din_s = sft_din_r;
        oen_s = sft_oen_r;
        case (state_s)
            ST_OE: begin
                vld_s = 1'b1;
                cmd_s = CMD_OE;
                oen_s = oe_lvl_s;
            end
`ifdef SFT_PRECLR_EN
            ST_CLR: begin
                vld_s = 1'b1;
                cmd_s = CMD_CLR;
            end
`endif
            ST_SHIFT: begin
                vld_s = 1'b1;
                cmd_s = CMD_SFT;
                din_s = img_s[{idx_s, 3'b000} +: 8];
            end
            ST_LATCH: begin
                vld_s = 1'b1;
                cmd_s = CMD_LAT;
            end
            default: vld_s = 1'b0;
        endcase
        // Ready is held low for the frm_done cycle and while an OE update waits
        rdy_s  = (state_s == ST_IDLE) && (state_r != ST_LWAIT) && !oe_pend_s;
        busy_s = (state_s != ST_IDLE) || oe_pend_s;
    end

    // FSM state, byte index, frame store and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            idx_r     <= 4'd0;
            frame_r   <= '0;
            cnt_r     <= 7'd0;
            oe_pend_r <= 1'b0;
            oe_lvl_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            oe_pend_r <= oe_pend_s;
            oe_lvl_r  <= oe_lvl_s;
            if (accept_s) begin
                frame_r <= frm_data;
            end
            if (state_s != state_r) begin
                cnt_r <= 7'd0;
            end else if ((state_r == ST_SWAIT) || (state_r == ST_LWAIT) || (state_r == ST_CWAIT)) begin
                cnt_r <= cnt_r + 7'd1;
            end else begin
                cnt_r <= 7'd0;
            end
        end
    end

    // Sticky timeout flag; a timeout beats a coincident clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sft_vld_r  <= 1'b0;
            sft_cmd_r  <= 2'b00;
            sft_din_r  <= 8'h00;
            sft_oen_r  <= 1'b0;
            frm_rdy_r  <= 1'b1;
            frm_done_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            sft_vld_r  <= vld_s;
            sft_cmd_r  <= cmd_s;
            sft_din_r  <= din_s;
            sft_oen_r  <= oen_s;
            frm_rdy_r  <= rdy_s;
            frm_done_r <= done_s;
            busy_r     <= busy_s;
        end
    end

    assign sft_vld     = sft_vld_r;
    assign sft_cmd     = sft_cmd_r;
    assign sft_din     = sft_din_r;
    assign sft_cmd_oen = sft_oen_r;
    assign frm_rdy     = frm_rdy_r;
    assign frm_done    = frm_done_r;
    assign busy        = busy_r;
    assign err         = err_r;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl with a 63-cycle shift driver model.
module tb_shift_ctrl;
    import shift_pkg::*;

    localparam int NBYTE = 4;
`ifdef SFT_PRECLR_EN
    localparam int OFS  = 3;
    localparam int NCLR = 1;
`else
    localparam int OFS  = 0;
    localparam int NCLR = 0;
`endif

    logic        clk, rst_n, frm_vld, frm_rdy, frm_done, oe_req, oe_val;
    logic        busy, err, err_clr, sft_vld, sft_cmd_oen, sft_done;
    logic [31:0] frm_data;
    logic [1:0]  sft_cmd;
    logic [7:0]  sft_din;
    logic        drv_done, man_done;
    bit          drv_en;
    int          dcnt;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        int         cyc;
        logic [1:0] cmd;
        logic [7:0] din;
        logic       oen;
    } ev_t;
    ev_t ev_q[$];
    int  done_q[$];

    typedef struct {
        logic [31:0]      data;
        logic [0:3][7:0]  seq;
    } vec_t;
    vec_t tbl[3];

    shift_ctrl #(.NBYTE(NBYTE), .TO_CYC(127)) dut (
        .clk(clk), .rst_n(rst_n), .frm_vld(frm_vld), .frm_data(frm_data),
        .frm_rdy(frm_rdy), .frm_done(frm_done), .oe_req(oe_req), .oe_val(oe_val),
        .busy(busy), .err(err), .err_clr(err_clr), .sft_vld(sft_vld),
        .sft_cmd(sft_cmd), .sft_cmd_oen(sft_cmd_oen), .sft_din(sft_din),
        .sft_done(sft_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    assign sft_done = drv_done | man_done;

    // driver: done pulses 63 cycles after each shift/latch command
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt     <= 0;
            drv_done <= 1'b0;
        end else begin
            drv_done <= 1'b0;
            if (sft_vld && drv_en && (sft_cmd == CMD_SFT || sft_cmd == CMD_LAT)) begin
                dcnt <= 62;
            end else if (dcnt > 0) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1) drv_done <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        ev_t e;
        if (sft_vld) begin
            e.cyc = cyc; e.cmd = sft_cmd; e.din = sft_din; e.oen = sft_cmd_oen;
            ev_q.push_back(e);
        end
        if (frm_done) done_q.push_back(cyc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ev_t get_ev(input int j);
        ev_t e;
        e.cyc = -1; e.cmd = 2'b00; e.din = 8'h00; e.oen = 1'b0;
        if (j < ev_q.size()) e = ev_q[j];
        return e;
    endfunction

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic clear_logs();
        ev_q.delete();
        done_q.delete();
    endtask

    // called at a negedge; returns at the negedge after the accept cycle
    task automatic send_frame(input logic [31:0] data, output int a);
        int n = 0;
        frm_data = data;
        frm_vld  = 1'b1;
        while (!frm_rdy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", {31'd0, frm_rdy}, 32'd1);
        a = cyc;
        @(negedge clk);
        frm_vld = 1'b0;
    endtask

    task automatic verify_frame(input string tag, input int a, input logic [0:3][7:0] seq,
                                input int j0, output int jn);
        ev_t e;
        int  j = j0;
`ifdef SFT_PRECLR_EN
        e = get_ev(j); j++;
        chk({tag, "_clr_cyc"}, e.cyc, a + 1);
        chk({tag, "_clr_cmd"}, {30'd0, e.cmd}, {30'd0, CMD_CLR});
`endif
        for (int k = 0; k < NBYTE; k++) begin
            e = get_ev(j); j++;
            chk($sformatf("%s_sft%0d_cyc", tag, k), e.cyc, a + 1 + OFS + 64 * k);
            chk($sformatf("%s_sft%0d_cmd", tag, k), {22'd0, e.cmd, e.din}, {22'd0, CMD_SFT, seq[k]});
        end
        e = get_ev(j); j++;
        chk({tag, "_lat_cyc"}, e.cyc, a + 1 + OFS + 256);
        chk({tag, "_lat_cmd"}, {30'd0, e.cmd}, {30'd0, CMD_LAT});
        chk({tag, "_done_n"}, done_q.size(), 1);
        chk({tag, "_done_cyc"}, (done_q.size() > 0) ? done_q[0] : -1, a + 321 + OFS);
        jn = j;
    endtask

    initial begin
        int a, x, jn;
        rst_n = 1'b0; frm_vld = 1'b0; frm_data = 32'h0; oe_req = 1'b0; oe_val = 1'b0;
        err_clr = 1'b0; man_done = 1'b0; drv_en = 1'b1;

        tbl[0].data = 32'hA1B2C3D4; tbl[0].seq = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
        tbl[1].data = 32'h00FF5A3C; tbl[1].seq = {8'h00, 8'hFF, 8'h5A, 8'h3C};
        tbl[2].data = 32'h80000001; tbl[2].seq = {8'h80, 8'h00, 8'h00, 8'h01};

        repeat (3) @(negedge clk);
        chk("rst_rdy", {31'd0, frm_rdy}, 32'd1);
        chk("rst_outs", {24'd0, sft_vld, sft_cmd, frm_done, busy, err, sft_cmd_oen, 1'b0},
            32'd0);
        chk("rst_din", {24'd0, sft_din}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // sft_done while idle must not start anything
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        @(negedge clk);
        chk("idle_done_vld", {31'd0, sft_vld}, 32'd0);
        chk("idle_done_rdy", {30'd0, frm_rdy, busy}, 32'd2);

        for (int i = 0; i < 3; i++) begin
            clear_logs();
            send_frame(tbl[i].data, a);
            if (i == 0) begin
                man_done = 1'b1;
                @(negedge clk);
                man_done = 1'b0;
            end
            wait_to(a + 321 + OFS);
            chk($sformatf("v%0d_rdy_at_done", i), {31'd0, frm_rdy}, 32'd0);
            wait_to(a + 322 + OFS);
            chk($sformatf("v%0d_rdy_after", i), {31'd0, frm_rdy}, 32'd1);
            wait_to(a + 325 + OFS);
            verify_frame($sformatf("v%0d", i), a, tbl[i].seq, 0, jn);
            chk($sformatf("v%0d_nev", i), ev_q.size(), jn);
        end

        // OE request coincident with a frame request in IDLE
        clear_logs();
        frm_data = tbl[0].data; frm_vld = 1'b1; oe_req = 1'b1; oe_val = 1'b1;
        x = cyc;
        @(negedge clk);
        oe_req = 1'b0;
        chk("co_oe_cmd", {28'd0, sft_vld, sft_cmd, sft_cmd_oen}, {28'd0, 1'b1, CMD_OE, 1'b1});
        chk("co_rdy_low", {31'd0, frm_rdy}, 32'd0);
        @(negedge clk);
        chk("co_rdy_high", {31'd0, frm_rdy}, 32'd1);
        @(negedge clk);
        frm_vld = 1'b0;
        wait_to(x + 2 + 325 + OFS);
        verify_frame("co", x + 2, tbl[0].seq, 1, jn);

        // OE request mid-frame is deferred until the frame completes
        clear_logs();
        send_frame(tbl[1].data, a);
        wait_to(a + 100);
        oe_req = 1'b1; oe_val = 1'b0;
        @(negedge clk);
        oe_req = 1'b0;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        wait_to(a + 321 + OFS);
        chk("mid_done_busy", {29'd0, frm_done, busy, sft_vld}, 32'd6);
        wait_to(a + 322 + OFS);
        chk("mid_oe_cmd", {27'd0, sft_vld, sft_cmd, sft_cmd_oen, busy},
            {27'd0, 1'b1, CMD_OE, 1'b0, 1'b1});
        wait_to(a + 323 + OFS);
        chk("mid_idle", {30'd0, busy, frm_rdy}, 32'd1);
        wait_to(a + 326 + OFS);
        verify_frame("mid", a, tbl[1].seq, 0, jn);
        chk("mid_oe_cyc", get_ev(jn).cyc, a + 322 + OFS);
        chk("mid_nev", ev_q.size(), jn + 1);

        // driver never answers: timeout, err_clr in the timeout cycle loses
        clear_logs();
        drv_en = 1'b0;
        send_frame(tbl[2].data, a);
        wait_to(a + 129 + OFS);
        chk("to_pre", {30'd0, err, frm_rdy}, 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to_err", {29'd0, err, frm_rdy, busy}, 32'd6);
        @(negedge clk);
        chk("to_sticky", {31'd0, err}, 32'd1);
        wait_to(a + 400);
        chk("to_no_done", done_q.size(), 0);
        chk("to_nev", ev_q.size(), 1 + NCLR);
        drv_en = 1'b1;
        clear_logs();
        send_frame(tbl[0].data, a);
        wait_to(a + 325 + OFS);
        verify_frame("to_next", a, tbl[0].seq, 0, jn);
        chk("to_err_kept", {31'd0, err}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("to_err_clr", {31'd0, err}, 32'd0);

        // reset mid-frame, then a clean frame
        clear_logs();
        send_frame(tbl[2].data, a);
        wait_to(a + 150);
        rst_n = 1'b0;
        #1;
        chk("mrst_outs", {29'd0, sft_vld, frm_rdy, busy}, 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("mrst_no_done", done_q.size(), 0);
        clear_logs();
        send_frame(tbl[1].data, a);
        wait_to(a + 325 + OFS);
        verify_frame("mrst_next", a, tbl[1].seq, 0, jn);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
